// File: rtl/spi_pkg.sv
// Shared SPI mode definitions and helpers for the SPI target endpoint.
// Imported by the synchroniser and the controller top.
package spi_pkg;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  localparam spi_mode_t MODE0 = '{cpol: 1'b0, cpha: 1'b0};
  localparam spi_mode_t MODE1 = '{cpol: 1'b0, cpha: 1'b1};
  localparam spi_mode_t MODE2 = '{cpol: 1'b1, cpha: 1'b0};
  localparam spi_mode_t MODE3 = '{cpol: 1'b1, cpha: 1'b1};

  // Word shifted out on MISO when the core had nothing ready.
  localparam logic [31:0] UNDERRUN_FILL = 32'hFFFF_FFFF;

  // 1 when MOSI is sampled on the rising sclk edge, 0 for the falling edge.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    return ~(mode.cpol ^ mode.cpha);
  endfunction

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchroniser for asynchronous SPI pins.
// RESET_VAL lets each pin come out of reset at its idle level.
module spi_sync
  import spi_pkg::*;
#(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] stage_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= {STAGES{RESET_VAL}};
    end else begin
      stage_q <= {stage_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/spi_target_ctrl.sv
// SPI target endpoint: oversampled pins, full-duplex word shifting, and
// valid/ready handshakes towards the core with overflow/underrun pulses.
module spi_target_ctrl
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int MSB_FIRST   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs_n,
  input  logic             sclk,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_val,
  input  logic             rx_rdy,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_val,
  output logic             tx_rdy,
  output logic             rx_ovf,
  output logic             tx_urun
);

  localparam int           CW          = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH - 1);
  localparam spi_mode_t    MODE        = '{cpol: 1'(CPOL), cpha: 1'(CPHA)};
  localparam logic         SAMPLE_RISE = sample_on_rise(MODE);
  localparam logic         LOAD_ON_CS  = (CPHA == 0);
  localparam logic         MSB         = (MSB_FIRST != 0);

  // Reset asserts asynchronously but releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end

  assign rst_int_n = rst_sync_q[1];

  logic sclk_s, cs_s, mosi_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'(CPOL))) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_int_n),
    .d_i  (sclk),
    .q_o  (sclk_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk  (clk),
    .rst_n(rst_int_n),
    .d_i  (cs_n),
    .q_o  (cs_s)
  );

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk  (clk),
    .rst_n(rst_int_n),
    .d_i  (mosi),
    .q_o  (mosi_s)
  );

  logic             sclk_hist_q, cs_hist_q;
  logic [WIDTH-1:0] rx_sr_q, rx_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             rx_val_q, rx_val_d;
  logic             rx_ovf_q, rx_ovf_d;
  logic [WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [WIDTH-1:0] hold_q, hold_d;
  logic             hold_full_q, hold_full_d;
  logic             tx_urun_q, tx_urun_d;
  logic             miso_oe_q, miso_oe_d;

  logic sclk_rise, sclk_fall;
  logic sample_edge, shift_edge;
  logic cs_fall, cs_rise;
  logic tx_load;
  logic [WIDTH-1:0] rx_shifted, tx_shifted;

  assign sclk_rise   = sclk_s & ~sclk_hist_q;
  assign sclk_fall   = ~sclk_s & sclk_hist_q;
  // A chip-select rise masks any sclk edge seen in the same cycle.
  assign sample_edge = ~cs_s & (SAMPLE_RISE ? sclk_rise : sclk_fall);
  assign shift_edge  = ~cs_s & (SAMPLE_RISE ? sclk_fall : sclk_rise);
  assign cs_fall     = ~cs_s & cs_hist_q;
  assign cs_rise     = cs_s & ~cs_hist_q;

  assign tx_load = (LOAD_ON_CS & cs_fall) | (shift_edge & (cnt_q == '0));

  assign rx_shifted = MSB ? {rx_sr_q[WIDTH-2:0], mosi_s}
                          : {mosi_s, rx_sr_q[WIDTH-1:1]};
  assign tx_shifted = MSB ? {tx_sr_q[WIDTH-2:0], 1'b0}
                          : {1'b0, tx_sr_q[WIDTH-1:1]};

  always_comb begin
    rx_sr_d     = rx_sr_q;
    cnt_d       = cnt_q;
    rx_data_d   = rx_data_q;
    rx_val_d    = rx_val_q;
    rx_ovf_d    = 1'b0;
    tx_sr_d     = tx_sr_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    tx_urun_d   = 1'b0;
    miso_oe_d   = ~cs_s;

    if (rx_val_q && rx_rdy) begin
      rx_val_d = 1'b0;
    end

    if (cs_rise) begin
      cnt_d   = '0;
      rx_sr_d = '0;
    end else if (sample_edge) begin
      rx_sr_d = rx_shifted;
      if (cnt_q == CNT_LAST) begin
        cnt_d     = '0;
        rx_data_d = rx_shifted;
        rx_val_d  = 1'b1;
        rx_ovf_d  = rx_val_q & ~rx_rdy;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    // An unfinished outgoing word is abandoned when the frame ends.
    if (cs_rise) begin
      tx_sr_d = '0;
    end else if (tx_load) begin
      if (hold_full_q) begin
        tx_sr_d     = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_sr_d   = UNDERRUN_FILL[WIDTH-1:0];
        tx_urun_d = 1'b1;
      end
    end else if (shift_edge) begin
      tx_sr_d = tx_shifted;
    end

    if (tx_val && !hold_full_q) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sclk_hist_q <= 1'(CPOL);
      cs_hist_q   <= 1'b1;
      rx_sr_q     <= '0;
      cnt_q       <= '0;
      rx_data_q   <= '0;
      rx_val_q    <= 1'b0;
      rx_ovf_q    <= 1'b0;
      tx_sr_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      tx_urun_q   <= 1'b0;
      miso_oe_q   <= 1'b0;
    end else begin
      sclk_hist_q <= sclk_s;
      cs_hist_q   <= cs_s;
      rx_sr_q     <= rx_sr_d;
      cnt_q       <= cnt_d;
      rx_data_q   <= rx_data_d;
      rx_val_q    <= rx_val_d;
      rx_ovf_q    <= rx_ovf_d;
      tx_sr_q     <= tx_sr_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      tx_urun_q   <= tx_urun_d;
      miso_oe_q   <= miso_oe_d;
    end
  end

  assign miso    = MSB ? tx_sr_q[WIDTH-1] : tx_sr_q[0];
  assign miso_oe = miso_oe_q;
  assign rx_data = rx_data_q;
  assign rx_val  = rx_val_q;
  assign rx_ovf  = rx_ovf_q;
  assign tx_rdy  = ~hold_full_q;
  assign tx_urun = tx_urun_q;

endmodule

// File: tb/tb_spi_target_ctrl.sv
// Directed + randomized bench for spi_target_ctrl: DUT A is mode 0 / 8-bit /
// MSB first, DUT B is mode 3 / 16-bit / LSB first, driven by a host model.
module tb_spi_target_ctrl;

  localparam int HP = 8;  // clk cycles per sclk phase

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] cs_pin   = 2'b11;
  logic [1:0] sclk_pin = 2'b10;  // A idles low (CPOL0), B idles high (CPOL1)
  logic [1:0] mosi_pin = 2'b00;

  logic        miso_a, miso_oe_a, rx_val_a, tx_rdy_a, rx_ovf_a, tx_urun_a;
  logic [7:0]  rx_data_a;
  logic        rx_rdy_a = 1'b1;
  logic [7:0]  tx_data_a = '0;
  logic        tx_val_a = 1'b0;

  logic        miso_b, miso_oe_b, rx_val_b, tx_rdy_b, rx_ovf_b, tx_urun_b;
  logic [15:0] rx_data_b;
  logic        rx_rdy_b = 1'b1;
  logic [15:0] tx_data_b = '0;
  logic        tx_val_b = 1'b0;

  spi_target_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .CPOL(0), .CPHA(0), .MSB_FIRST(1)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_pin[0]), .sclk(sclk_pin[0]), .mosi(mosi_pin[0]),
    .miso(miso_a), .miso_oe(miso_oe_a), .rx_data(rx_data_a), .rx_val(rx_val_a),
    .rx_rdy(rx_rdy_a), .tx_data(tx_data_a), .tx_val(tx_val_a), .tx_rdy(tx_rdy_a),
    .rx_ovf(rx_ovf_a), .tx_urun(tx_urun_a)
  );

  spi_target_ctrl #(.WIDTH(16), .SYNC_STAGES(2), .CPOL(1), .CPHA(1), .MSB_FIRST(0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .cs_n(cs_pin[1]), .sclk(sclk_pin[1]), .mosi(mosi_pin[1]),
    .miso(miso_b), .miso_oe(miso_oe_b), .rx_data(rx_data_b), .rx_val(rx_val_b),
    .rx_rdy(rx_rdy_b), .tx_data(tx_data_b), .tx_val(tx_val_b), .tx_rdy(tx_rdy_b),
    .rx_ovf(rx_ovf_b), .tx_urun(tx_urun_b)
  );

  int tests = 0;
  int fails = 0;

  // Scoreboard side: every accepted RX word plus pulse counters.
  logic [15:0] rxq_a[$];
  logic [15:0] rxq_b[$];
  int ovf_cnt_a = 0, urun_cnt_a = 0;
  int urun_snap = 0;

  always @(negedge clk) begin
    if (rx_val_a === 1'b1 && rx_rdy_a === 1'b1) rxq_a.push_back({8'h00, rx_data_a});
    if (rx_val_b === 1'b1 && rx_rdy_b === 1'b1) rxq_b.push_back(rx_data_b);
    if (rx_ovf_a === 1'b1) ovf_cnt_a <= ovf_cnt_a + 1;
    if (tx_urun_a === 1'b1) urun_cnt_a <= urun_cnt_a + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic miso_of(input int sel);
    return (sel == 0) ? miso_a : miso_b;
  endfunction

  function automatic logic tx_rdy_of(input int sel);
    return (sel == 0) ? tx_rdy_a : tx_rdy_b;
  endfunction

  task automatic wait_hp();
    repeat (HP) @(negedge clk);
  endtask

  task automatic cs_assert(input int sel);
    cs_pin[sel] = 1'b0;
    wait_hp();
    chk("miso_oe_active", (sel == 0) ? miso_oe_a : miso_oe_b, 1);
  endtask

  task automatic cs_release(input int sel);
    wait_hp();
    cs_pin[sel] = 1'b1;
    wait_hp();
    wait_hp();
  endtask

  // One SPI bit as the host sees it; MISO is read just before the sample edge.
  task automatic host_bit(input int sel, input logic b, input bit last, output logic got);
    logic cpol, cpha;
    cpol = (sel != 0);
    cpha = (sel != 0);
    if (!cpha) begin
      mosi_pin[sel] = b;
      wait_hp();
      got = miso_of(sel);
      sclk_pin[sel] = ~cpol;
      wait_hp();
      if (last) urun_snap = urun_cnt_a;
      sclk_pin[sel] = cpol;
    end else begin
      sclk_pin[sel] = ~cpol;
      mosi_pin[sel] = b;
      wait_hp();
      got = miso_of(sel);
      if (last) urun_snap = urun_cnt_a;
      sclk_pin[sel] = cpol;
      wait_hp();
    end
  endtask

  task automatic host_frame(input int sel, input int nbits, input logic [15:0] w0,
                            input logic [15:0] w1, output logic [15:0] g0,
                            output logic [15:0] g1);
    int w, k, b, pos;
    logic [15:0] cur;
    logic got;
    w = (sel == 0) ? 8 : 16;
    g0 = '0;
    g1 = '0;
    cs_assert(sel);
    for (int i = 0; i < nbits; i++) begin
      k = i / w;
      b = i % w;
      pos = (sel == 0) ? (w - 1 - b) : b;
      cur = (k == 0) ? w0 : w1;
      host_bit(sel, cur[pos], (i == nbits - 1), got);
      if (k == 0) g0[pos] = got;
      else g1[pos] = got;
    end
    cs_release(sel);
  endtask

  task automatic give_tx(input int sel, input logic [15:0] w);
    int n = 0;
    while (tx_rdy_of(sel) !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("tx_rdy_before_load", tx_rdy_of(sel), 1);
    if (sel == 0) begin tx_data_a = w[7:0]; tx_val_a = 1'b1; end
    else begin tx_data_b = w; tx_val_b = 1'b1; end
    @(negedge clk);
    tx_val_a = 1'b0;
    tx_val_b = 1'b0;
    chk("tx_rdy_after_capture", tx_rdy_of(sel), 0);
  endtask

  task automatic pop_rx(input int sel, input string tag, input logic [15:0] exp);
    logic [15:0] v;
    if (sel == 0) begin
      chk({tag, "_count"}, rxq_a.size(), 1);
      v = (rxq_a.size() > 0) ? rxq_a.pop_front() : 16'hxxxx;
    end else begin
      chk({tag, "_count"}, rxq_b.size(), 1);
      v = (rxq_b.size() > 0) ? rxq_b.pop_front() : 16'hxxxx;
    end
    chk(tag, v, exp);
  endtask

  initial begin
    logic [15:0] g0, g1, rw, tw;
    logic b;
    int snap0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx_rdy_a", tx_rdy_a, 1);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("rst_rx_data_a", rx_data_a, 0);
    chk("rst_rx_val_a", rx_val_a, 0);
    chk("rst_miso_oe_a", miso_oe_a, 0);
    chk("rst_miso_a", miso_a, 0);
    chk("rst_ovf_urun_a", {rx_ovf_a, tx_urun_a}, 0);
    chk("rst_rx_val_b", rx_val_b, 0);
    chk("rst_tx_rdy_b", tx_rdy_b, 1);
    chk("rst_miso_oe_b", miso_oe_b, 0);

    // Mode 0, 8-bit: rx 0xA5, tx 0x3C
    give_tx(0, 16'h003C);
    host_frame(0, 8, 16'h00A5, 16'h0000, g0, g1);
    pop_rx(0, "m0_rx", 16'h00A5);
    chk("m0_miso", g0, 16'h003C);
    chk("m0_tx_rdy_back", tx_rdy_a, 1);
    chk("m0_miso_oe_idle", miso_oe_a, 0);

    // Mode 3, 16-bit, LSB first: rx 0x1234, tx 0xBEEF
    give_tx(1, 16'hBEEF);
    host_frame(1, 16, 16'h1234, 16'h0000, g0, g1);
    pop_rx(1, "m3_rx", 16'h1234);
    chk("m3_miso", g0, 16'hBEEF);
    chk("m3_tx_rdy_back", tx_rdy_b, 1);

    // Back-to-back words with one tx word: second MISO word is the fill
    give_tx(0, 16'h0077);
    snap0 = urun_cnt_a;
    host_frame(0, 16, 16'h00C3, 16'h003C, g0, g1);
    chk("b2b_miso0", g0, 16'h0077);
    chk("b2b_miso1", g1, 16'h00FF);
    chk("b2b_urun_pulses", urun_snap - snap0, 1);
    chk("b2b_rx_count", rxq_a.size(), 2);
    chk("b2b_rx0", (rxq_a.size() > 0) ? rxq_a.pop_front() : 16'hxxxx, 16'h00C3);
    chk("b2b_rx1", (rxq_a.size() > 0) ? rxq_a.pop_front() : 16'hxxxx, 16'h003C);

    // Overflow: consumer stalled across two words
    rx_rdy_a = 1'b0;
    snap0 = ovf_cnt_a;
    host_frame(0, 16, 16'h0011, 16'h0022, g0, g1);
    chk("ovf_pulses", ovf_cnt_a - snap0, 1);
    chk("ovf_rx_val", rx_val_a, 1);
    chk("ovf_rx_data", rx_data_a, 8'h22);
    rx_rdy_a = 1'b1;
    repeat (3) @(negedge clk);
    chk("ovf_rx_val_cleared", rx_val_a, 0);
    pop_rx(0, "ovf_delivered", 16'h0022);

    // Aborted frame after 5 bits, then a full frame
    host_frame(0, 5, 16'h00FF, 16'h0000, g0, g1);
    chk("abort_miso_oe", miso_oe_a, 0);
    chk("abort_no_rx", rxq_a.size(), 0);
    host_frame(0, 8, 16'h0081, 16'h0000, g0, g1);
    pop_rx(0, "after_abort_rx", 16'h0081);

    // Asynchronous reset in the middle of a word
    cs_assert(0);
    for (int i = 0; i < 3; i++) host_bit(0, 1'b1, 1'b0, b);
    give_tx(0, 16'h0099);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_rx_data", rx_data_a, 0);
    chk("midrst_tx_rdy", tx_rdy_a, 1);
    chk("midrst_miso_oe", miso_oe_a, 0);
    chk("midrst_miso", miso_a, 0);
    cs_pin[0] = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    host_frame(0, 8, 16'h005A, 16'h0000, g0, g1);
    pop_rx(0, "post_rst_rx", 16'h005A);

    // Randomized single-word frames checked against the host-side model
    for (int n = 0; n < 6; n++) begin
      rw = 16'($urandom_range(0, 255));
      tw = 16'($urandom_range(0, 255));
      give_tx(0, tw);
      host_frame(0, 8, rw, 16'h0000, g0, g1);
      pop_rx(0, "rand_a_rx", rw);
      chk("rand_a_miso", g0, tw);
    end
    for (int n = 0; n < 4; n++) begin
      rw = 16'($urandom);
      tw = 16'($urandom);
      give_tx(1, tw);
      host_frame(1, 16, rw, 16'h0000, g0, g1);
      pop_rx(1, "rand_b_rx", rw);
      chk("rand_b_miso", g0, tw);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
